// File: rtl/usr_pkg.sv
// Shared types for the universal shift register: operation encodings and burst FSM states.
package usr_pkg;

  typedef enum logic [2:0] {
    MODE_HOLD = 3'b000,
    MODE_SHL  = 3'b001,
    MODE_SHR  = 3'b010,
    MODE_ROL  = 3'b011,
    MODE_ROR  = 3'b100,
    MODE_LOAD = 3'b101,
    MODE_ASR  = 3'b110,
    MODE_CLR  = 3'b111
  } mode_t;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  // Only movement operations can be repeated as a counted burst.
  function automatic logic is_shift_mode(input mode_t m);
    return (m == MODE_SHL) || (m == MODE_SHR) || (m == MODE_ROL) ||
           (m == MODE_ROR) || (m == MODE_ASR);
  endfunction

endpackage

// File: rtl/usr_bit.sv
// One register bit: picks its next value from itself, a neighbour, or the load bit.
module usr_bit
  import usr_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  step,
  input  mode_t op,
  input  logic  d,
  input  logic  lo_nb,
  input  logic  hi_nb,
  output logic  q
);

  logic nxt;

  // lo_nb feeds left moves, hi_nb feeds right moves; edge bits get serial/wrap values from the top.
  always_comb begin
    nxt = q;
    case (op)
      MODE_SHL, MODE_ROL:           nxt = lo_nb;
      MODE_SHR, MODE_ROR, MODE_ASR: nxt = hi_nb;
      MODE_LOAD:                    nxt = d;
      MODE_CLR:                     nxt = 1'b0;
      default:                      nxt = q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= 1'b0;
    end else if (step) begin
      q <= nxt;
    end
  end

endmodule

// File: rtl/universal_shift_register.sv
// Eight-mode shift register with a counted burst engine (START/LEN, BUSY/DONE).
module universal_shift_register
  import usr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LENW  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sil,
  input  logic             sir,
  input  logic             start,
  input  logic [LENW-1:0]  len,
  output logic [WIDTH-1:0] q,
  output logic             sol,
  output logic             sor,
  output logic             busy,
  output logic             done
);

  state_t          state, state_nxt;
  logic [LENW-1:0] cnt, cnt_nxt;
  mode_t           burst_mode, burst_mode_nxt;
  mode_t           cur_mode, op;
  logic            done_nxt;
  logic            step;
  logic            msb_in;
  logic [WIDTH-1:0] lo_nb, hi_nb;

  assign cur_mode = mode_t'(mode);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      burst_mode <= MODE_HOLD;
      done       <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      burst_mode <= burst_mode_nxt;
      done       <= done_nxt;
    end
  end

  // A zero-length burst request completes at once without ever entering BURST.
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    burst_mode_nxt = burst_mode;
    done_nxt       = 1'b0;
    case (state)
      IDLE: begin
        if (start && is_shift_mode(cur_mode)) begin
          if (len != '0) begin
            state_nxt      = BURST;
            cnt_nxt        = len;
            burst_mode_nxt = cur_mode;
          end else begin
            done_nxt = 1'b1;
          end
        end
      end
      BURST: begin
        if (en) begin
          cnt_nxt = cnt - 1'b1;
          if (cnt == LENW'(1)) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The edge that accepts a burst request performs no step of its own.
  always_comb begin
    op   = cur_mode;
    step = 1'b0;
    case (state)
      IDLE:    step = en && !(start && is_shift_mode(cur_mode));
      BURST: begin
        op   = burst_mode;
        step = en;
      end
      default: step = 1'b0;
    endcase
  end

  assign busy = (state == BURST);

  always_comb begin
    if (op == MODE_ROR) begin
      msb_in = q[0];
    end else if (op == MODE_ASR) begin
      msb_in = q[WIDTH-1];
    end else begin
      msb_in = sil;
    end
    lo_nb = {q[WIDTH-2:0], (op == MODE_ROL) ? q[WIDTH-1] : sir};
    hi_nb = {msb_in, q[WIDTH-1:1]};
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    usr_bit u_bit (
      .clk   (clk),
      .rst_n (rst_n),
      .step  (step),
      .op    (op),
      .d     (d[i]),
      .lo_nb (lo_nb[i]),
      .hi_nb (hi_nb[i]),
      .q     (q[i])
    );
  end

  assign sol = q[WIDTH-1];
  assign sor = q[0];

endmodule

// File: tb/tb_universal_shift_register.sv
// Directed bench: arithmetic reference model checked every cycle plus literal spot checks.
module tb_universal_shift_register;

  localparam int W = 8;
  localparam int L = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic [2:0]   mode;
  logic [W-1:0] d;
  logic         sil, sir, start;
  logic [L-1:0] len;
  logic [W-1:0] q;
  logic         sol, sor, busy, done;

  int checks = 0;
  int failures = 0;
  int done_total = 0;

  logic [W-1:0] mq;
  logic         mbusy, mdone;
  int           remaining;
  logic [2:0]   bmode;

  universal_shift_register #(.WIDTH(W), .LENW(L)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .d(d), .sil(sil), .sir(sir),
    .start(start), .len(len), .q(q), .sol(sol), .sor(sor), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] apply(input logic [2:0] m, input logic [W-1:0] v,
                                         input logic [W-1:0] dv, input logic si_l, input logic si_r);
    logic [W-1:0] r;
    case (m)
      3'd1: r = (v << 1) | W'(si_r);
      3'd2: r = (v >> 1) | (W'(si_l) << (W - 1));
      3'd3: r = (v << 1) | (v >> (W - 1));
      3'd4: r = (v >> 1) | (v << (W - 1));
      3'd5: r = dv;
      3'd6: r = W'($signed(v) >>> 1);
      3'd7: r = '0;
      default: r = v;
    endcase
    return r;
  endfunction

  function automatic logic movement(input logic [2:0] m);
    return (m == 3'd1) || (m == 3'd2) || (m == 3'd3) || (m == 3'd4) || (m == 3'd6);
  endfunction

  // Reference behaviour: a remaining-steps counter drives the burst, plain arithmetic does the data.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq = '0; mbusy = 1'b0; mdone = 1'b0; remaining = 0; bmode = 3'd0;
    end else begin
      logic pulse;
      pulse = 1'b0;
      if (mbusy) begin
        if (en) begin
          mq = apply(bmode, mq, d, sil, sir);
          remaining = remaining - 1;
          if (remaining == 0) begin mbusy = 1'b0; pulse = 1'b1; end
        end
      end else if (start && movement(mode)) begin
        if (len == 0) pulse = 1'b1;
        else begin mbusy = 1'b1; remaining = int'(len); bmode = mode; end
      end else if (en) begin
        mq = apply(mode, mq, d, sil, sir);
      end
      mdone = pulse;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      checkOutput("model_q", 32'(q), 32'(mq));
      checkOutput("model_sol", 32'(sol), 32'(mq[W-1]));
      checkOutput("model_sor", 32'(sor), 32'(mq[0]));
      checkOutput("model_busy", 32'(busy), 32'(mbusy));
      checkOutput("model_done", 32'(done), 32'(mdone));
      if (done === 1'b1) done_total++;
    end
  end

  task automatic applyStimulus(input logic e, input logic [2:0] m, input logic [W-1:0] dv,
                               input logic sl, input logic sr, input logic st, input logic [L-1:0] ln);
    en = e; mode = m; d = dv; sil = sl; sir = sr; start = st; len = ln;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int busy_cnt, done_at, ndone, dt0;

  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b0, 3'd0, '0, 1'b0, 1'b0, 1'b0, '0);
    tick(2);
    rst_n = 1'b1;
    tick(1);

    // Asynchronous reset mid-cycle with a full register.
    applyStimulus(1'b1, 3'd5, 8'hFF, 1'b0, 1'b0, 1'b0, '0);
    tick(1);
    checkOutput("load_ff", 32'(q), 32'h00FF);
    mode = 3'd0;
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    checkOutput("reset_q", 32'(q), 32'h0);
    checkOutput("reset_busy", 32'(busy), 32'h0);
    checkOutput("reset_done", 32'(done), 32'h0);
    tick(1);
    rst_n = 1'b1;
    tick(1);

    // Single steps.
    applyStimulus(1'b1, 3'd5, 8'hB4, 1'b0, 1'b0, 1'b0, '0); tick(1);
    checkOutput("load_b4", 32'(q), 32'hB4);
    applyStimulus(1'b1, 3'd1, 8'h00, 1'b0, 1'b1, 1'b0, '0); tick(1);
    checkOutput("shl", 32'(q), 32'h69);
    applyStimulus(1'b1, 3'd4, 8'h00, 1'b0, 1'b0, 1'b0, '0); tick(1);
    checkOutput("ror", 32'(q), 32'hB4);
    applyStimulus(1'b1, 3'd6, 8'h00, 1'b0, 1'b0, 1'b0, '0); tick(1);
    checkOutput("asr", 32'(q), 32'hDA);
    checkOutput("asr_sol", 32'(sol), 32'h1);
    checkOutput("asr_sor", 32'(sor), 32'h0);
    applyStimulus(1'b1, 3'd7, 8'h00, 1'b0, 1'b0, 1'b0, '0); tick(1);
    checkOutput("clr", 32'(q), 32'h00);

    // Burst ROL x3 from 0x81.
    applyStimulus(1'b1, 3'd5, 8'h81, 1'b0, 1'b0, 1'b0, '0); tick(1);
    applyStimulus(1'b1, 3'd3, 8'h00, 1'b0, 1'b0, 1'b1, 4'd3); tick(1);
    applyStimulus(1'b1, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0);
    busy_cnt = 0; done_at = -1; ndone = 0;
    for (int c = 1; c <= 6; c++) begin
      if (done && done_at < 0) done_at = c;
      busy_cnt += int'(busy); ndone += int'(done);
      tick(1);
    end
    checkOutput("rol_busy_cycles", 32'(busy_cnt), 32'd3);
    checkOutput("rol_done_cycle", 32'(done_at), 32'd4);
    checkOutput("rol_done_count", 32'(ndone), 32'd1);
    checkOutput("rol_q", 32'(q), 32'h0C);

    // Burst SHR x4 with a two-cycle stall and a wandering MODE input.
    applyStimulus(1'b1, 3'd7, 8'h00, 1'b0, 1'b0, 1'b0, '0); tick(1);
    applyStimulus(1'b1, 3'd2, 8'h55, 1'b1, 1'b0, 1'b1, 4'd4); tick(1);
    start = 1'b0;
    busy_cnt = 0; done_at = -1; ndone = 0;
    for (int c = 1; c <= 10; c++) begin
      if (done && done_at < 0) done_at = c;
      busy_cnt += int'(busy); ndone += int'(done);
      en = !(c == 2 || c == 3);
      mode = (c <= 6) ? 3'(c % 8) : 3'd0;
      tick(1);
    end
    checkOutput("stall_busy_cycles", 32'(busy_cnt), 32'd6);
    checkOutput("stall_done_cycle", 32'(done_at), 32'd7);
    checkOutput("stall_done_count", 32'(ndone), 32'd1);
    checkOutput("stall_q", 32'(q), 32'hF0);

    // Zero-length burst, START ignored while busy, new START in the DONE cycle.
    applyStimulus(1'b1, 3'd5, 8'h3C, 1'b0, 1'b0, 1'b0, '0); tick(1);
    applyStimulus(1'b1, 3'd1, 8'h00, 1'b0, 1'b1, 1'b1, 4'd0); tick(1);
    applyStimulus(1'b1, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0);
    checkOutput("len0_done", 32'(done), 32'h1);
    checkOutput("len0_busy", 32'(busy), 32'h0);
    checkOutput("len0_q", 32'(q), 32'h3C);
    tick(1);
    checkOutput("len0_done_low", 32'(done), 32'h0);
    applyStimulus(1'b1, 3'd2, 8'h00, 1'b0, 1'b0, 1'b1, 4'd2); tick(1);
    done_at = -1; ndone = 0;
    for (int c = 1; c <= 6; c++) begin
      if (done && done_at < 0) done_at = c;
      ndone += int'(done);
      case (c)
        1: begin start = 1'b1; mode = 3'd3; len = 4'd5; end
        3: begin start = 1'b1; mode = 3'd3; len = 4'd1; end
        default: begin start = 1'b0; mode = 3'd0; end
      endcase
      tick(1);
    end
    checkOutput("busy_start_done_cycle", 32'(done_at), 32'd3);
    checkOutput("busy_start_done_count", 32'(ndone), 32'd2);
    checkOutput("busy_start_q", 32'(q), 32'h1E);

    // Reset during the second step of a five-step burst.
    applyStimulus(1'b1, 3'd7, 8'h00, 1'b0, 1'b0, 1'b0, '0); tick(1);
    applyStimulus(1'b1, 3'd1, 8'h00, 1'b0, 1'b1, 1'b1, 4'd5); tick(1);
    applyStimulus(1'b1, 3'd0, 8'h00, 1'b0, 1'b1, 1'b0, 4'd0); tick(1);
    checkOutput("abort_q_step1", 32'(q), 32'h01);
    dt0 = done_total;
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    checkOutput("abort_q", 32'(q), 32'h0);
    checkOutput("abort_busy", 32'(busy), 32'h0);
    tick(2);
    rst_n = 1'b1;
    tick(8);
    checkOutput("abort_no_done", 32'(done_total - dt0), 32'd0);
    checkOutput("abort_q_after", 32'(q), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
